// File: rtl/counter_seq_defs.sv
// Shared constants for the counter sequencer: FSM encodings, synchronizer depth
// and the decoded button command bundle.
package counter_seq_defs;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef struct packed {
    logic load;
    logic stop;
    logic start;
  } cmd_t;

endpackage

// File: rtl/key_pulse.sv
// Active-low push-button synchronizer with falling-edge detection; emits one
// registered pulse per press no matter how long the button is held.
module key_pulse
  import counter_seq_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], key_n};
      prev_q <= sync_q[SYNC_DEPTH-1];
      pulse  <= prev_q & ~sync_q[SYNC_DEPTH-1];
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an external up/down counter from board buttons and switches with a
// prescaled count rate and optional stop-at-terminal behaviour.
module counter_sequencer
  import counter_seq_defs::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             sw_dir,
  input  logic             sw_mode,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_en,
  output logic             sload,
  output logic [WIDTH-1:0] sdata,
  output logic             updown,
  output logic             running,
  output logic             done
);

  localparam int unsigned     PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  cmd_t            cmd;
  logic [2:0]      state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            cnt_en_d;
  logic            tick;
  logic            terminal;

  key_pulse u_start (.clk(CLOCK_50), .rst_n(Resetn), .key_n(start_n), .pulse(cmd.start));
  key_pulse u_stop  (.clk(CLOCK_50), .rst_n(Resetn), .key_n(stop_n),  .pulse(cmd.stop));
  key_pulse u_load  (.clk(CLOCK_50), .rst_n(Resetn), .key_n(load_n),  .pulse(cmd.load));

  assign tick     = (ps_q == PS_LAST);
  assign terminal = updown ? (q == {WIDTH{1'b1}}) : (q == '0);

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    cnt_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.load)       state_d = ST_LOAD;
        else if (cmd.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cmd.load) begin
          state_d = ST_LOAD;
        end else if (cmd.stop) begin
          state_d = ST_PAUSE;
        end else begin
          ps_d = tick ? '0 : ps_q + 1'b1;
          // A terminal tick parks in DONE instead of stepping the counter.
          if (tick) begin
            if (sw_mode && terminal) state_d  = ST_DONE;
            else                     cnt_en_d = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (cmd.load)       state_d = ST_LOAD;
        else if (cmd.start) state_d = ST_RUN;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        ps_d    = '0;
      end
      ST_DONE: begin
        if (cmd.load) state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
        ps_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ps_q    <= '0;
      cnt_en  <= 1'b0;
      sload   <= 1'b0;
      sdata   <= '0;
      updown  <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cnt_en  <= cnt_en_d;
      sload   <= (state_d == ST_LOAD);
      running <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
      if (state_d == ST_LOAD) sdata  <= sw_data;
      if (state_q != ST_RUN)  updown <= sw_dir;
    end
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences an external LPM up/down counter in the counter demo top level.
- Turns board push-buttons and switches into the counter's control strobes: count enable, synchronous load, load data and direction.
- Generates a prescaled count rate from CLOCK_50 and supports wrap or stop-at-terminal operation.
- Sits between the board I/O (KEY/SW) and the counter instance. The counter's q is fed back for terminal detection.

Parameters:
- WIDTH, 8, counter width in bits (sdata, q).
- PRESCALE, 5000000, CLOCK_50 cycles per count step (10 Hz at 50 MHz). Minimum 2.
- PS_W, $clog2(PRESCALE), prescaler width (derived localparam, not overridable).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- start_n  in  1  start/resume push-button, active-low, asynchronous to clock.
- stop_n  in  1  pause push-button, active-low, asynchronous.
- load_n  in  1  load push-button, active-low, asynchronous.
- sw_data  in  WIDTH  load value from switches.
- sw_dir  in  1  direction select: 1 = up, 0 = down.
- sw_mode  in  1  0 = wrap at terminal, 1 = stop at terminal.
- q  in  WIDTH  current count fed back from the counter.
- cnt_en  out  1  one-cycle count-enable strobe to the counter.
- sload  out  1  one-cycle synchronous-load strobe to the counter.
- sdata  out  WIDTH  load data to the counter.
- updown  out  1  direction to the counter.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.

Behaviour:
- Reset (Resetn low, async):
  - state = IDLE, prescaler = 0.
  - cnt_en = 0, sload = 0, sdata = 0, updown = 1, running = 0, done = 0.
  - Synchronizer flops reset to 1 (button released).
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then falling-edge detection, giving a registered one-cycle cmd pulse.
  - A button held low produces exactly one pulse.
  - Latency: a level sampled low at edge k gives a pulse high in the cycle after edge k+2. The resulting state change occurs at edge k+3.
- Command priority when pulses coincide: load > stop > start.
- States:
  - IDLE:
    - load -> LOAD.
    - start -> RUN.
    - stop ignored.
  - RUN:
    - Prescaler increments every cycle.
    - At PRESCALE-1 the prescaler wraps to 0 and a tick occurs.
    - On a tick, cnt_en = 1 for exactly one cycle, except in the DONE case below.
    - stop -> PAUSE; prescaler holds its value.
    - load -> LOAD.
    - If tick and sw_mode = 1 and q is at terminal (all ones when updown = 1, zero when updown = 0): -> DONE, with no cnt_en on that tick.
  - PAUSE:
    - Prescaler frozen.
    - start -> RUN; prescaler resumes from the held value.
    - load -> LOAD.
  - LOAD:
    - Exactly one cycle.
    - sload = 1 and sdata = sw_data captured on the edge that entered LOAD.
    - Prescaler cleared to 0.
    - Unconditional -> IDLE.
  - DONE:
    - done = 1, cnt_en held 0.
    - load -> LOAD.
    - start and stop ignored.
- Direction:
  - updown is registered from sw_dir in every state except RUN.
  - Frozen during RUN so that direction and terminal compare stay consistent.
- Wrap mode (sw_mode = 0): no terminal check; the counter wraps naturally.
- sw_mode is sampled live.
- Invariants:
  - cnt_en and sload are never high in the same cycle.
  - All outputs are registered; no combinational input-to-output path.
- Reset mid-operation:
  - Immediately forces the reset values, including dropping any in-flight cnt_en or sload.
  - Pending edge detections are discarded.

Decomposition:
- Shared package/header counter_seq_defs holds:
  - State encodings (IDLE = 0, RUN = 1, PAUSE = 2, LOAD = 3, DONE = 4; 3-bit).
  - Synchronizer depth constant (2).
- Sub-module key_pulse: synchronizer plus falling-edge detector with async active-low reset. Instantiated three times (start, stop, load).

Test Plan (PRESCALE=4, WIDTH=4, counter model in bench):
- Reset release, no keys -> all outputs at reset values for 20 cycles; state IDLE.
- sw_data=4'hA, pulse load_n low 5 cycles -> exactly one sload cycle with sdata=A; model q=A; back to IDLE, cnt_en never asserted.
- start_n pulse, sw_dir=1, sw_mode=0 from q=A:
  - cnt_en every 4th cycle.
  - q runs B,C,D,E,F,0,1.
  - running=1 throughout.
- Mid-run stop_n pulse at prescaler=2, then start_n 10 cycles later -> no cnt_en while paused; first cnt_en exactly 2 cycles after resume enters RUN.
- sw_mode=1, sw_dir=0, load 4'h2, start -> q=2,1,0, then done=1 on the next tick with no further cnt_en; later start pulse ignored; load pulse exits to IDLE.
- Edge cases:
  - load_n and stop_n pulsed in the same cycle during RUN -> LOAD wins.
  - Resetn asserted during the sload cycle -> sload drops to 0 asynchronously.
  - Toggling sw_dir during RUN does not change updown.
